// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial pattern transmitter.
package seqgen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSend = 2'b01,
        StGap  = 2'b10,
        StDone = 2'b11
    } state_e;

    localparam int unsigned   DefPatW    = 5;
    localparam logic [4:0]    DefPattern = 5'b11011;
    localparam int unsigned   DefGapLen  = 2;
    localparam int unsigned   GapW       = 4;
    localparam int unsigned   RepsW      = 4;

endpackage

// File: rtl/sequence_gen11011.sv
// Serial pattern transmitter: shifts PATTERN out MSB first, optionally repeated
// with an idle gap between passes; reports busy and a one-cycle done pulse.
module sequence_gen11011
    import seqgen_pkg::*;
#(
    parameter int unsigned      PAT_W   = DefPatW,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DefPattern),
    parameter int unsigned      GAP_LEN = DefGapLen
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RepsW-1:0] reps,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     IdxW    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IdxW-1:0] IdxTop  = IdxW'(PAT_W - 1);
    localparam logic [GapW-1:0] GapLoad = (GAP_LEN == 0) ? '0 : GapW'(GAP_LEN - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RepsW-1:0]  pass_left_q, pass_left_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pass_left_d = pass_left_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    pass_left_d = reps;
                    idx_d       = IdxTop;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IdxW'(1);
                end else if (pass_left_q != '0) begin
                    pass_left_d = pass_left_q - RepsW'(1);
                    idx_d       = IdxTop;
                    if (GAP_LEN == 0) begin
                        state_d = StSend;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = GapLoad;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == '0) begin
                    state_d = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        out_valid_d = (state_d == StSend);
        out_d       = out_valid_d ? PATTERN[idx_d] : 1'b0;
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pass_left_q <= '0;
            gap_cnt_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pass_left_q <= pass_left_d;
            gap_cnt_q   <= gap_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_gen11011.sv
// Scoreboard bench: two transmitters (gap 2 and gap 0) driven by shared stimulus,
// each compared cycle by cycle against a frame-list reference model.
module tb_sequence_gen11011;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] reps;
    logic       out0, val0, busy0, done0;
    logic       out1, val1, busy1, done1;

    always #5 clk = ~clk;

    sequence_gen11011 dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reps      (reps),
        .abort     (abort),
        .out       (out0),
        .out_valid (val0),
        .busy      (busy0),
        .done      (done0)
    );

    sequence_gen11011 #(.GAP_LEN(0)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reps      (reps),
        .abort     (abort),
        .out       (out1),
        .out_valid (val1),
        .busy      (busy1),
        .done      (done1)
    );

    // Tuple layout: {out, out_valid, busy, done}
    typedef logic [3:0] tup_t;
    localparam tup_t Idle = 4'b0000;

    tup_t exp_q   [2][$];
    tup_t frame_q [2][$];
    tup_t cur     [2];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int gap_len(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Whole transmission as a list of per-cycle outputs, built from the pass/gap rules.
    function automatic void build_frame(input int d, input logic [3:0] r);
        logic [4:0] pat;
        pat = 5'b11011;
        for (int p = 0; p <= int'(r); p++) begin
            for (int i = 4; i >= 0; i--) frame_q[d].push_back({pat[i], 3'b110});
            if (p < int'(r))
                for (int j = 0; j < gap_len(d); j++) frame_q[d].push_back(4'b0010);
        end
        frame_q[d].push_back(4'b0011);
    endfunction

    task automatic model_edge();
        tup_t nxt;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                frame_q[d].delete();
                nxt = Idle;
            end else if (cur[d][1] && !cur[d][0] && abort) begin
                frame_q[d].delete();
                nxt = Idle;
            end else if (frame_q[d].size() > 0) begin
                nxt = frame_q[d].pop_front();
            end else if (!cur[d][1] && start) begin
                build_frame(d, reps);
                nxt = frame_q[d].pop_front();
            end else begin
                nxt = Idle;
            end
            cur[d] = nxt;
            exp_q[d].push_back(nxt);
        end
    endtask

    task automatic step(input logic s, input logic [3:0] r, input logic a);
        start = s;
        reps  = r;
        abort = a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        tup_t e;
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                if (d == 0) check("dut0_cycle", {28'd0, out0, val0, busy0, done0}, {28'd0, e});
                else        check("dut1_cycle", {28'd0, out1, val1, busy1, done1}, {28'd0, e});
            end
        end
    end

    initial begin
        int          b0, b1, nbits;
        logic [31:0] bits;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        reps  = '0;
        cur[0] = Idle;
        cur[1] = Idle;
        #12;
        check("reset_dut0", {28'd0, out0, val0, busy0, done0}, 32'd0);
        check("reset_dut1", {28'd0, out1, val1, busy1, done1}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single pass
        step(1'b1, 4'd0, 1'b0);
        repeat (8) step(1'b0, 4'd0, 1'b0);

        // Two passes: busy length with and without the gap
        b0 = 0; b1 = 0;
        step(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            b0 += int'(busy0);
            b1 += int'(busy1);
            step(1'b0, 4'd0, 1'b0);
        end
        check("busy_cycles_reps1_gap2", b0, 13);
        check("busy_cycles_reps1_gap0", b1, 11);

        // Three passes: back-to-back bit stream on the gap-0 instance
        b0 = 0; b1 = 0; nbits = 0; bits = '0;
        step(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 60; i++) begin
            b0 += int'(busy0);
            b1 += int'(busy1);
            if (val1) begin
                bits = {bits[30:0], out1};
                nbits++;
            end
            step(1'b0, 4'd0, 1'b0);
        end
        check("busy_cycles_reps2_gap2", b0, 20);
        check("busy_cycles_reps2_gap0", b1, 16);
        check("b2b_bit_count", nbits, 15);
        check("b2b_bit_stream", bits, 32'b110111101111011);

        // start while busy is ignored
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        repeat (10) step(1'b0, 4'd0, 1'b0);

        // Abort on the third bit, then restart from the MSB
        step(1'b1, 4'd1, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        check("abort_valid_busy", {30'd0, val0, busy0}, 32'd0);
        repeat (3) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        check("restart_msb", {30'd0, out0, val0}, 32'b11);
        repeat (8) step(1'b0, 4'd0, 1'b0);

        // Asynchronous reset while dut0 sits in its gap
        step(1'b1, 4'd1, 1'b0);
        repeat (5) step(1'b0, 4'd0, 1'b0);
        check("in_gap", {30'd0, val0, busy0}, 32'b01);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_dut0", {28'd0, out0, val0, busy0, done0}, 32'd0);
        check("async_reset_dut1", {28'd0, out1, val1, busy1, done1}, 32'd0);
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0) exp_q[d][exp_q[d].size() - 1] = Idle;
            frame_q[d].delete();
            cur[d] = Idle;
        end
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        rst = 1'b0;
        repeat (4) step(1'b0, 4'd0, 1'b0);
        check("idle_after_reset", {30'd0, busy0, busy1}, 32'd0);

        // Random traffic
        repeat (1500) begin
            step(($urandom % 8) == 0, 4'($urandom), ($urandom % 16) == 0);
        end
        repeat (200) step(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q[0].size() + exp_q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_gen11011.md
# sequence_gen11011

Serial pattern transmitter. It is the sending end of the team's serial sequence detectors. On a start request it shifts a fixed bit pattern (default 11011) out on a single line, MSB first, one bit per clock. It can repeat the pattern with an idle gap between passes, and it reports busy/done status to the controlling logic. It drives stimulus lines into detector FSMs and the pattern ports of the lab board.

## Interface
- `PAT_W`, default 5: pattern length in bits, 2..16.
- `PATTERN`, default 5'b11011: bits transmitted, MSB (`PATTERN[PAT_W-1]`) first.
- `GAP_LEN`, default 2: idle cycles between repeated passes, 0..15. 0 means passes run back-to-back.
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request a transmission. Sampled only in IDLE.
- `reps` input, 4 bits: extra passes. Total passes = `reps`+1. Sampled together with `start`.
- `abort` input, 1 bit: synchronous cancel of the transmission in progress.
- `out` output, 1 bit: serial data, registered. Driven 0 whenever `out_valid`=0.
- `out_valid` output, 1 bit: `out` carries a pattern bit this cycle.
- `busy` output, 1 bit: high in SEND, GAP and DONE.
- `done` output, 1 bit: one-cycle pulse after the final bit of the final pass.

## Operation
- Moore FSM with states IDLE, SEND, GAP and DONE. All outputs are registered and decoded from state plus counters.
- Internal registers:
  - bit index `idx` (`$clog2(PAT_W)` bits, counts down).
  - pass counter `pass_left` (4 bits).
  - gap counter `gap_cnt` (4 bits).
- IDLE:
  - With `start`=1, load `pass_left`=`reps` and `idx`=`PAT_W`-1, then go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `out`=`PATTERN[idx]`, `out_valid`=1.
  - If `idx`>0, decrement `idx`.
  - If `idx`=0 and `pass_left`>0: decrement `pass_left` and reload `idx`. Then go to GAP (loading `gap_cnt`=`GAP_LEN`-1), or straight back to SEND when `GAP_LEN`=0.
  - If `idx`=0 and `pass_left`=0, go to DONE.
- GAP:
  - `out`=0, `out_valid`=0.
  - Go to SEND when `gap_cnt`=0; otherwise decrement `gap_cnt`.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `abort`=1 in SEND or GAP:
  - Next state is IDLE and `out_valid` drops immediately on that edge.
  - `done` is not pulsed.
  - `abort` has priority over every other transition. It has no effect in IDLE or DONE.
- `start` is ignored while `busy`=1. No queuing.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Reset values: state=IDLE; `out`, `out_valid`, `busy`, `done` all 0; counters 0.
- `rst` asserted mid-frame clears everything immediately (asynchronous). The frame is lost and no `done` is pulsed.
- `start`=1 at rising edge k: after edge k, `busy`=1, `out_valid`=1, `out`=`PATTERN[PAT_W-1]`.
- Bit i (MSB index `PAT_W`-1 down to 0) is valid after edge k+(`PAT_W`-1-i).
- One pass occupies `PAT_W` cycles.
- Each further pass starts `PAT_W`+`GAP_LEN` cycles after the previous one started.
- `done` is high for one cycle after the final bit, then IDLE. The earliest accepted restart is `start` at the edge that enters IDLE+1, i.e. one cycle after `done`.
- Total busy cycles = (`reps`+1)·`PAT_W` + `reps`·`GAP_LEN` + 1.

## Structure
- Shared package `seqgen_pkg`:
  - state encoding constants IDLE/SEND/GAP/DONE (2 bits).
  - default `PATTERN`/`PAT_W`.
  - `GAP_LEN` width constant.
- Single module, no sub-module: the counters are trivial and local to the FSM.

## Test plan
- Single pass: reset, then `start`=1 for 1 cycle with `reps`=0.
  - Required: `out`=1,1,0,1,1 on 5 consecutive cycles with `out_valid`=1.
  - Then `done`=1 for 1 cycle, then `busy`=0.
- Repeat with gap: `reps`=1, `GAP_LEN`=2.
  - Required: 11011, two cycles with `out_valid`=0 and `out`=0, then 11011, then `done`.
  - 13 busy cycles total.
- Back-to-back: `GAP_LEN`=0, `reps`=2.
  - Required: 15 consecutive valid bits 110111101111011, then `done`.
- `start` pulsed during bit 3 of a pass.
  - Required: ignored. Sequence and `done` timing are unchanged.
- Abort: `abort`=1 on the third bit.
  - Required: next cycle `out_valid`=0, `busy`=0, and no `done` pulse.
  - A new `start` afterwards restarts from the MSB.
- Asynchronous reset mid-GAP.
  - Required: all outputs are 0 immediately after `rst` rises, and the FSM stays in IDLE until `start`.
